// File: rtl/evp_operand_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : evp_operand_server                                               |
// | Purpose : Coefficient store and operand sequencer for the polynomial       |
// |           evaluator; captures the evaluator's result and status.           |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module evp_operand_server #(
    parameter int MAX_N  = 16,
    parameter int DATA_W = 16,
    parameter int N_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_load,
    input  logic [N_W-1:0]    load_N,
    input  logic [DATA_W-1:0] load_x,
    input  logic              wr_coef_en,
    input  logic [DATA_W-1:0] wr_coef,
    input  logic              go,
    output logic              start_evp,
    input  logic              en_rd_data,
    input  logic              en_rd_S,
    input  logic              en_rd_N,
    input  logic              done_evp,
    input  logic [31:0]       result_in,
    input  logic [31:0]       status_in,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] c_i,
    output logic [N_W-1:0]    N,
    output logic              busy,
    output logic              ready,
    output logic              err,
    output logic              underrun,
    output logic [31:0]       result_out,
    output logic [31:0]       status_out,
    output logic              result_valid
);

    localparam int           AW        = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [N_W:0] MAX_N_EXT = (N_W+1)'(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [MAX_N];
    logic [DATA_W-1:0] x_st;
    logic [N_W-1:0]    n_st;
    logic [N_W-1:0]    wr_ptr;
    logic [N_W:0]      rd_ptr;

    logic load_legal;
    logic load_take;
    logic go_fire;
    logic coef_wr;
    logic last_wr;

    always_comb begin
        load_legal = (load_N != '0) && ({1'b0, load_N} <= MAX_N_EXT);
        load_take  = cmd_load && (state == S_IDLE || state == S_LOAD || state == S_ARMED);
        go_fire    = (state == S_ARMED) && go && !cmd_load;
        coef_wr    = (state == S_LOAD) && wr_coef_en && !cmd_load;
        last_wr    = coef_wr && (wr_ptr == n_st - 1'b1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_load && load_legal) state_nx = S_LOAD;
            end
            S_LOAD, S_ARMED: begin
                if (cmd_load)     state_nx = load_legal ? S_LOAD : S_IDLE;
                else if (last_wr) state_nx = S_ARMED;
                else if (go_fire) state_nx = S_RUN;
            end
            S_RUN: begin
                if (done_evp) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_ARMED;
            default: state_nx = S_IDLE;
        endcase
    end

    // Store contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (coef_wr) mem[wr_ptr[AW-1:0]] <= wr_coef;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_st         <= '0;
            n_st         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            start_evp    <= 1'b0;
            x            <= '0;
            c_i          <= '0;
            N            <= '0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            err          <= 1'b0;
            underrun     <= 1'b0;
            result_out   <= '0;
            status_out   <= 32'hFFFF_FFFF;
            result_valid <= 1'b0;
        end else begin
            start_evp <= go_fire;
            busy      <= (state_nx == S_LOAD) || (state_nx == S_RUN);
            ready     <= (state_nx == S_ARMED);

            if (load_take) begin
                if (load_legal) begin
                    n_st         <= load_N;
                    x_st         <= load_x;
                    wr_ptr       <= '0;
                    err          <= 1'b0;
                    result_valid <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end else if (coef_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (go_fire) begin
                rd_ptr       <= '0;
                underrun     <= 1'b0;
                result_valid <= 1'b0;
            end

            if (state == S_RUN) begin
                if (en_rd_data) x <= x_st;
                if (en_rd_N)    N <= n_st;
                // The pop at rd_ptr == N is the evaluator's normal trailing pop;
                // only pops beyond it count as underrun.
                if (en_rd_S) begin
                    if (rd_ptr < {1'b0, n_st}) c_i <= mem[rd_ptr[AW-1:0]];
                    else                       c_i <= '0;
                    if (rd_ptr > {1'b0, n_st}) underrun <= 1'b1;
                    else                       rd_ptr   <= rd_ptr + 1'b1;
                end
                if (done_evp) begin
                    result_out   <= result_in;
                    status_out   <= status_in;
                    result_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_evp_operand_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_evp_operand_server                                            |
// | Purpose : Scoreboard bench for the evaluator operand server.               |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_evp_operand_server;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_load = 1'b0;
    logic [4:0]  load_N = '0;
    logic [15:0] load_x = '0;
    logic        wr_coef_en = 1'b0;
    logic [15:0] wr_coef = '0;
    logic        go = 1'b0;
    logic        start_evp;
    logic        en_rd_data = 1'b0;
    logic        en_rd_S = 1'b0;
    logic        en_rd_N = 1'b0;
    logic        done_evp = 1'b0;
    logic [31:0] result_in = '0;
    logic [31:0] status_in = '0;
    logic [15:0] x;
    logic [15:0] c_i;
    logic [4:0]  N;
    logic        busy;
    logic        ready;
    logic        err;
    logic        underrun;
    logic [31:0] result_out;
    logic [31:0] status_out;
    logic        result_valid;

    evp_operand_server #(.MAX_N(16), .DATA_W(16), .N_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_load(cmd_load), .load_N(load_N), .load_x(load_x),
        .wr_coef_en(wr_coef_en), .wr_coef(wr_coef), .go(go),
        .start_evp(start_evp),
        .en_rd_data(en_rd_data), .en_rd_S(en_rd_S), .en_rd_N(en_rd_N),
        .done_evp(done_evp), .result_in(result_in), .status_in(status_in),
        .x(x), .c_i(c_i), .N(N),
        .busy(busy), .ready(ready), .err(err), .underrun(underrun),
        .result_out(result_out), .status_out(status_out), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model of the evaluator-facing side
    logic [15:0] m_mem [16];
    int          m_n;
    logic [15:0] m_x;
    int          m_rd;
    logic        m_ur;

    logic [15:0] exp_ci [$];
    logic        exp_ur [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coefs(input int n);
        for (int i = 0; i < n; i++) begin
            wr_coef_en = 1'b1;
            wr_coef    = m_mem[i];
            step();
        end
        wr_coef_en = 1'b0;
        check("armed_ready", ready, 1);
        check("armed_busy", busy, 0);
    endtask

    task automatic load(input int n, input logic [15:0] xv);
        cmd_load = 1'b1;
        load_N   = n[4:0];
        load_x   = xv;
        step();
        cmd_load = 1'b0;
        m_n = n;
        m_x = xv;
        check("load_busy", busy, 1);
        check("load_err", err, 0);
        check("load_rv", result_valid, 0);
        write_coefs(n);
    endtask

    task automatic go_run();
        go = 1'b1;
        step();
        go = 1'b0;
        m_rd = 0;
        m_ur = 1'b0;
        check("start_hi", start_evp, 1);
        check("run_busy", busy, 1);
        check("go_ur_clr", underrun, 0);
        check("go_rv_clr", result_valid, 0);
        step();
        check("start_lo", start_evp, 0);
    endtask

    task automatic pop(input bit first);
        logic [15:0] e;
        e = (m_rd < m_n) ? m_mem[m_rd] : 16'h0;
        if (m_rd > m_n) m_ur = 1'b1;
        else            m_rd++;
        exp_ci.push_back(e);
        exp_ur.push_back(m_ur);
        en_rd_S    = 1'b1;
        en_rd_data = first;
        en_rd_N    = first;
        step();
        en_rd_S    = 1'b0;
        en_rd_data = 1'b0;
        en_rd_N    = 1'b0;
        check("c_i", c_i, exp_ci.pop_front());
        check("underrun", underrun, exp_ur.pop_front());
        if (first) begin
            check("x", x, m_x);
            check("N", N, m_n);
        end
    endtask

    task automatic finish_run(input logic [31:0] res, input logic [31:0] st);
        done_evp  = 1'b1;
        result_in = res;
        status_in = st;
        step();
        done_evp = 1'b0;
        check("result_out", result_out, res);
        check("status_out", status_out, st);
        check("result_valid", result_valid, 1);
        check("done_busy", busy, 0);
        step();
        check("rearm_ready", ready, 1);
        check("hold_result", result_out, res);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"}, start_evp, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_ci"}, c_i, 0);
        check({tag, "_N"}, N, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ur"}, underrun, 0);
        check({tag, "_res"}, result_out, 0);
        check({tag, "_stat"}, status_out, 32'hFFFF_FFFF);
        check({tag, "_rv"}, result_valid, 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_vals("rst");

        // Illegal loads: zero and above the store depth
        cmd_load = 1'b1; load_N = 5'd0; load_x = 16'd5;
        step();
        check("err_n0", err, 1);
        check("idle_ready", ready, 0);
        check("idle_busy", busy, 0);
        load_N = 5'd17;
        step();
        cmd_load = 1'b0;
        check("err_n17", err, 1);
        check("idle_busy2", busy, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        check("idle_go_ignored", start_evp, 0);

        // Basic run: N=3, x=2, coefs 1,2,3
        m_mem[0] = 16'd1; m_mem[1] = 16'd2; m_mem[2] = 16'd3;
        load(3, 16'd2);
        go_run();
        pop(1'b1);
        for (int i = 0; i < 3; i++) pop(1'b0);
        finish_run(32'd17, 32'd0);

        // Re-run without reload
        go_run();
        pop(1'b1);
        for (int i = 0; i < 3; i++) pop(1'b0);
        finish_run(32'd42, 32'h5);

        // Over-pop: fifth pop sets underrun, next go clears it
        go_run();
        pop(1'b1);
        for (int i = 0; i < 4; i++) pop(1'b0);
        check("ur_sticky", underrun, 1);
        finish_run(32'hDEAD_BEEF, 32'h1);
        check("ur_after_done", underrun, 1);
        go_run();
        finish_run(32'h0, 32'h0);

        // cmd_load and go together in ARMED: load wins
        m_mem[0] = 16'd9; m_mem[1] = 16'd8;
        cmd_load = 1'b1; go = 1'b1; load_N = 5'd2; load_x = 16'd7;
        step();
        cmd_load = 1'b0; go = 1'b0;
        m_n = 2; m_x = 16'd7;
        check("coll_start", start_evp, 0);
        check("coll_busy", busy, 1);
        check("coll_ready", ready, 0);
        check("coll_rv", result_valid, 0);
        step();
        check("coll_start2", start_evp, 0);
        write_coefs(2);
        go_run();
        pop(1'b1);
        pop(1'b0);
        pop(1'b0);

        // Asynchronous reset mid-run
        rst = 1'b0;
        #1;
        check_reset_vals("arst");
        step();
        rst = 1'b1;
        en_rd_S = 1'b1; en_rd_data = 1'b1; en_rd_N = 1'b1;
        done_evp = 1'b1; result_in = 32'd99; status_in = 32'd3;
        step();
        en_rd_S = 1'b0; en_rd_data = 1'b0; en_rd_N = 1'b0; done_evp = 1'b0;
        check_reset_vals("idle_strobes");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
